riscv_mem_arbiter: RTL and testbench

Shares one fixed-latency memory between the instruction-fetch port (read-only) and the load/store port (read/write). One access is in flight at a time. The block sequences the memory enables for exactly LATENCY cycles, captures read data, and returns a one-cycle ready pulse to the granted requester. It sits between the fetch/LSU stages and the shared RAM, and makes a standalone ready counter on the memory side unnecessary.

---
 rtl/riscv_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one fixed-latency memory between the instruction-fetch port and the
// load/store port. One access is in flight at a time: IDLE samples requests,
// ACCESS drives the memory enables for LATENCY cycles, and RESP returns a
// one-cycle ready pulse to the granted port.
//
// Optional feature macro: RISCV_ARB_ROUND_ROBIN_EN
//   defined   : a last-grant pointer breaks D/I ties round-robin
//   undefined : fixed D-over-I priority, no pointer register
//
// state  | meaning
// IDLE   | sample requests, latch the winner's command
// ACCESS | memory enable high, counter runs 0..LATENCY-1
// RESP   | ready pulse to the granted port, enables low
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              gnt_d_q;
  logic              rden_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              pick_d_d;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
  // 1 = D port was granted last; reset value means I was last, so D wins the first tie
  logic              last_d_q;

  // Winner select: on a tie the port not granted last wins
  always_comb begin
    pick_d_d = d_req;
    if (d_req && i_req) begin
      pick_d_d = ~last_d_q;
    end
  end
`else
  // Winner select: fixed D-over-I priority
  always_comb begin
    pick_d_d = d_req;
  end
`endif

  // Arbiter FSM with registered memory controls, ready pulses and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_d_q   <= 1'b0;
      rden_q    <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d_q <= pick_d_d;
            addr_q  <= pick_d_d ? d_addr : i_addr;
            if (pick_d_d) begin
              wdata_q <= d_wdata;
            end
            wren_q  <= pick_d_d && d_we;
            rden_q  <= !(pick_d_d && d_we);
            cnt_q   <= 4'd0;
            state_q <= ACCESS;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
            last_d_q <= pick_d_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            cnt_q  <= 4'd0;
            // Stores leave both read-data registers untouched
            if (!wren_q) begin
              if (gnt_d_q) begin
                d_rdata_q <= mem_rdata;
              end else begin
                i_rdata_q <= mem_rdata;
              end
            end
            if (gnt_d_q) begin
              d_ready_q <= 1'b1;
            end else begin
              i_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_d   = gnt_d_q;
  assign mem_rden  = rden_q;
  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: scenario tasks with inline checks plus a
// ready-driven scoreboard that verifies port and returned data of every access.
module tb_riscv_mem_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        grant_d;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h40) return 32'h0000_0013;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Memory model: data is only valid in the last enabled cycle
  always @(posedge clk) begin
    if (mem_rden || mem_wren) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign mem_rdata = (mem_rden && acc_cnt == LAT - 1) ? rd_model(mem_addr) : 32'hBAD0_BAD0;

  // Scoreboard: every ready pulse pops one expected access
  always @(negedge clk) begin
    exp_t e;
    if (i_ready || d_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: i_ready=%0b d_ready=%0b, required no ready", i_ready, d_ready);
      end else begin
        e = sb_q.pop_front();
        if ({d_ready, i_ready} !== {e.is_d, ~e.is_d}) begin
          fails++;
          $display("FAIL sb_port: d/i ready=%b%b, required %b%b", d_ready, i_ready, e.is_d, ~e.is_d);
        end
        tests++;
        if ((e.is_d ? d_rdata : i_rdata) !== e.data) begin
          fails++;
          $display("FAIL sb_data: got %h, required %h", e.is_d ? d_rdata : i_rdata, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sb_empty(input string name);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_sb_left: %0d pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_fetch();
    tick();
    i_req = 1'b1; i_addr = 32'h40;
    sb_q.push_back('{1'b0, 32'h0000_0013});
    tests++;
    if (busy !== 1'b0 || mem_rden !== 1'b0) begin
      fails++; $display("FAIL fetch_c0: busy=%b rden=%b, required 0 0", busy, mem_rden);
    end
    for (int c = 1; c <= LAT; c++) begin
      tick();
      i_addr = 32'hFFF;
      tests++;
      if ({mem_rden, mem_wren, busy, i_ready, d_ready} !== 5'b10100 || mem_addr !== 32'h40) begin
        fails++;
        $display("FAIL fetch_access c%0d: rden/wren/busy/ir/dr=%b%b%b%b%b addr=%h, required 10100 addr=40",
                 c, mem_rden, mem_wren, busy, i_ready, d_ready, mem_addr);
      end
    end
    tick();
    tests++;
    if ({i_ready, d_ready, mem_rden, mem_wren} !== 4'b1000 || i_rdata !== 32'h13) begin
      fails++;
      $display("FAIL fetch_resp: ir/dr/rden/wren=%b%b%b%b rdata=%h, required 1000 rdata=13",
               i_ready, d_ready, mem_rden, mem_wren, i_rdata);
    end
    i_req = 1'b0;
    tick();
    tests++;
    if (i_ready !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'h13) begin
      fails++; $display("FAIL fetch_after: ir=%b busy=%b rdata=%h, required 0 0 13", i_ready, busy, i_rdata);
    end
    check_sb_empty("fetch");
  endtask

  task automatic test_store();
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    sb_q.push_back('{1'b1, 32'h0});
    for (int c = 1; c <= LAT; c++) begin
      tick();
      d_wdata = 32'h1234_5678;
      tests++;
      if ({mem_wren, mem_rden, d_ready} !== 3'b100 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100) begin
        fails++;
        $display("FAIL store_access c%0d: wren/rden/dr=%b%b%b wdata=%h addr=%h, required 100 DEADBEEF 100",
                 c, mem_wren, mem_rden, d_ready, mem_wdata, mem_addr);
      end
    end
    tick();
    tests++;
    if ({d_ready, i_ready, mem_wren, mem_rden} !== 4'b1000 || d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL store_resp: dr/ir/wren/rden=%b%b%b%b d_rdata=%h, required 1000 0",
               d_ready, i_ready, mem_wren, mem_rden, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tests++;
    if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100 || busy !== 1'b0) begin
      fails++; $display("FAIL store_hold: wdata=%h addr=%h busy=%b, required DEADBEEF 100 0", mem_wdata, mem_addr, busy);
    end
    check_sb_empty("store");
  endtask

  task automatic test_reset();
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({i_ready, d_ready, mem_rden, mem_wren, busy, grant_d} !== 6'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b%b%b%b%b%b ir=%h dr=%h a=%h w=%h, required all 0",
               i_ready, d_ready, mem_rden, mem_wren, busy, grant_d, i_rdata, d_rdata, mem_addr, mem_wdata);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    tick();
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    sb_q.push_back('{1'b1, rd_model(32'h200)});
    sb_q.push_back('{1'b0, rd_model(32'h80)});
    for (int c = 1; c <= 10; c++) begin
      tick();
      tests++;
      if (d_ready !== (c == 4) || i_ready !== (c == 9)) begin
        fails++; $display("FAIL prio_ready c%0d: dr=%b ir=%b", c, d_ready, i_ready);
      end
      if (c == 4) d_req = 1'b0;
      if (c == 9) i_req = 1'b0;
      if (c == 1 || c == 6) begin
        tests++;
        if (grant_d !== (c == 1) || mem_addr !== (c == 1 ? 32'h200 : 32'h80) || mem_rden !== 1'b1) begin
          fails++;
          $display("FAIL prio_grant c%0d: grant_d=%b addr=%h rden=%b", c, grant_d, mem_addr, mem_rden);
        end
      end
      if (c == 5) begin
        tests++;
        if (busy !== 1'b0 || grant_d !== 1'b1) begin
          fails++; $display("FAIL prio_gap: busy=%b grant_d=%b, required 0 1", busy, grant_d);
        end
      end
    end
    check_sb_empty("prio");
  endtask

  task automatic test_reset_mid_access();
    tick();
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    tick();
    #2 rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    tests++;
    if (mem_rden !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid: rden=%b busy=%b, required 0 0", mem_rden, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests++;
      if (i_ready !== 1'b0 || busy !== 1'b0 || mem_rden !== 1'b0) begin
        fails++; $display("FAIL rst_mid_after c%0d: ir=%b busy=%b rden=%b, required 0 0 0", c, i_ready, busy, mem_rden);
      end
    end
    check_sb_empty("rst_mid");
  endtask

  task automatic test_contention();
    logic exp_d;
    tick();
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      sb_q.push_back('{exp_d, exp_d ? rd_model(32'h200) : rd_model(32'h80)});
    end
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c % 5 == 1) begin
`ifdef RISCV_ARB_ROUND_ROBIN_EN
        exp_d = ((c / 5) % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        tests++;
        if (grant_d !== exp_d || busy !== 1'b1) begin
          fails++; $display("FAIL rr_grant c%0d: grant_d=%b busy=%b, required %b 1", c, grant_d, busy, exp_d);
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    check_sb_empty("rr");
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #13 rst_n = 1'b1;
    test_fetch();
    test_store();
    test_reset();
    test_priority();
    test_reset_mid_access();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
